// File: rtl/int_seq_ctrl.sv
// rtl/int_seq_ctrl.sv - IRQ/FIQ entry and return sequencer with one level of FIQ-over-IRQ nesting
module int_seq_ctrl #(
    parameter logic [31:0] IRQ_VEC = 32'h0000_0018,
    parameter logic [31:0] FIQ_VEC = 32'h0000_001C
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        EX_irq,
    input  logic        EX_fiq,
    input  logic        CPSR_7,
    input  logic        CPSR_6,
    input  logic        ret,
    output logic        INTA_irq,
    output logic        INTA_fiq,
    output logic        Write_LR,
    output logic        Write_SPSR,
    output logic        Write_PC,
    output logic [1:0]  PC_s,
    output logic [31:0] INT_Vector,
    output logic        Set_I,
    output logic        Set_F,
    output logic        Restore_CPSR,
    output logic        busy,
    output logic        nest
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACK     = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_VECT    = 3'd3;
    localparam logic [2:0] S_SERVICE = 3'd4;
    localparam logic [2:0] S_RET     = 3'd5;

    logic [2:0] state, state_nxt;
    logic       src, src_nxt;
    logic       src_outer, src_outer_nxt;
    logic       nest_nxt;
    logic       irq_d, fiq_d;
    logic       irq_arm, fiq_arm;
    logic       pend_irq, pend_fiq;
    logic       irq_rise, fiq_rise;
    logic       irq_ok, fiq_ok;

    // A line must be seen low after reset before its rising edge counts.
    assign irq_rise = EX_irq & ~irq_d & irq_arm;
    assign fiq_rise = EX_fiq & ~fiq_d & fiq_arm;
    assign irq_ok   = pend_irq & ~CPSR_7;
    assign fiq_ok   = pend_fiq & ~CPSR_6;

    always_comb begin
        state_nxt     = state;
        src_nxt       = src;
        src_outer_nxt = src_outer;
        nest_nxt      = nest;
        case (state)
            S_IDLE: begin
                if (fiq_ok || irq_ok) begin
                    state_nxt = S_ACK;
                    src_nxt   = fiq_ok;
                end
            end
            S_ACK:  state_nxt = S_SAVE;
            S_SAVE: state_nxt = S_VECT;
            S_VECT: state_nxt = S_SERVICE;
            S_SERVICE: begin
                if (ret) begin
                    state_nxt = S_RET;
                end else if (!src && !nest && fiq_ok) begin
                    state_nxt     = S_ACK;
                    src_outer_nxt = src;
                    src_nxt       = 1'b1;
                    nest_nxt      = 1'b1;
                end
            end
            S_RET: begin
                if (nest) begin
                    nest_nxt  = 1'b0;
                    src_nxt   = src_outer;
                    state_nxt = S_SERVICE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= S_IDLE;
            src          <= 1'b0;
            src_outer    <= 1'b0;
            nest         <= 1'b0;
            irq_d        <= 1'b0;
            fiq_d        <= 1'b0;
            irq_arm      <= 1'b0;
            fiq_arm      <= 1'b0;
            pend_irq     <= 1'b0;
            pend_fiq     <= 1'b0;
            INTA_irq     <= 1'b0;
            INTA_fiq     <= 1'b0;
            Write_LR     <= 1'b0;
            Write_SPSR   <= 1'b0;
            Write_PC     <= 1'b0;
            PC_s         <= 2'b00;
            INT_Vector   <= 32'h0;
            Set_I        <= 1'b0;
            Set_F        <= 1'b0;
            Restore_CPSR <= 1'b0;
            busy         <= 1'b0;
        end else begin
            irq_d        <= EX_irq;
            fiq_d        <= EX_fiq;
            irq_arm      <= irq_arm | ~EX_irq;
            fiq_arm      <= fiq_arm | ~EX_fiq;
            pend_irq     <= irq_rise | (pend_irq & ~INTA_irq);
            pend_fiq     <= fiq_rise | (pend_fiq & ~INTA_fiq);
            state        <= state_nxt;
            src          <= src_nxt;
            src_outer    <= src_outer_nxt;
            nest         <= nest_nxt;
            INTA_irq     <= (state_nxt == S_ACK) & ~src_nxt;
            INTA_fiq     <= (state_nxt == S_ACK) & src_nxt;
            Write_LR     <= (state_nxt == S_SAVE);
            Write_SPSR   <= (state_nxt == S_SAVE);
            Write_PC     <= (state_nxt == S_VECT) | (state_nxt == S_RET);
            PC_s         <= (state_nxt == S_VECT) ? 2'b11 :
                            (state_nxt == S_RET)  ? 2'b10 : 2'b00;
            Set_I        <= (state_nxt == S_VECT);
            Set_F        <= (state_nxt == S_VECT) & src_nxt;
            Restore_CPSR <= (state_nxt == S_RET);
            busy         <= (state_nxt != S_IDLE);
            if (state_nxt == S_VECT) begin
                INT_Vector <= src_nxt ? FIQ_VEC : IRQ_VEC;
            end
        end
    end

endmodule

// File: doc/int_seq_ctrl.md
# int_seq_ctrl

Interrupt entry/return sequencer for the CPU's interrupt datapath. Captures external IRQ and FIQ request edges, arbitrates them against the CPSR I/F mask bits, and drives a fixed multi-cycle sequence: acknowledge, context save, vector load, service, return. Supports one level of nesting: an FIQ may preempt an IRQ handler. Sits between the request sources and the PC/LR/SPSR/CPSR write controls of the datapath.

## Interface
Parameters:
- IRQ_VEC, 32'h0000_0018, IRQ handler address.
- FIQ_VEC, 32'h0000_001C, FIQ handler address.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset clr, asynchronous, active-high.
- EX_irq  in  1  IRQ request, synchronous to clk; rising edge = request.
- EX_fiq  in  1  FIQ request, synchronous to clk; rising edge = request.
- CPSR_7  in  1  I mask (1 = IRQ masked).
- CPSR_6  in  1  F mask (1 = FIQ masked).
- ret  in  1  one-cycle pulse, handler executed return.
- INTA_irq  out  1  IRQ acknowledge pulse.
- INTA_fiq  out  1  FIQ acknowledge pulse.
- Write_LR  out  1  save return PC to banked LR.
- Write_SPSR  out  1  save CPSR to banked SPSR.
- Write_PC  out  1  PC write enable.
- PC_s  out  2  PC source: 00 PC+4, 10 LR (return), 11 INT_Vector.
- INT_Vector  out  32  handler address.
- Set_I  out  1  force CPSR I=1.
- Set_F  out  1  force CPSR F=1.
- Restore_CPSR  out  1  copy SPSR to CPSR.
- busy  out  1  any state other than IDLE.
- nest  out  1  FIQ running on top of an IRQ.

## Operation
- Request capture: pend_irq/pend_fiq set on 0->1 of EX_irq/EX_fiq (one-cycle delayed compare). Cleared by own INTA. Set and clear in the same cycle: set wins. Repeated edges while pending merge into one request.
- Arbitration (evaluated in IDLE and SERVICE): fiq_ok = pend_fiq & ~CPSR_6; irq_ok = pend_irq & ~CPSR_7. FIQ beats IRQ.
- States:
  - IDLE: fiq_ok or irq_ok -> ACK, with src latched (1 = FIQ).
  - ACK: INTA_<src>=1 -> SAVE.
  - SAVE: Write_LR=1, Write_SPSR=1 -> VECT.
  - VECT: Write_PC=1, PC_s=11, INT_Vector=src?FIQ_VEC:IRQ_VEC, Set_I=1, Set_F=src -> SERVICE.
  - SERVICE: ret -> RET. Else if active src is IRQ, nest=0, and fiq_ok -> ACK with src=FIQ, and nest set at ACK. IRQ never preempts anything. ret has priority over preemption.
  - RET: Write_PC=1, PC_s=10, Restore_CPSR=1. If nest=1: nest<=0, active src<=IRQ -> SERVICE. Else -> IDLE.
- Two-entry source stack: outer (IRQ) src is kept while the FIQ runs.
- All control outputs are registered Moore outputs of the current state. Outside the listed states they are 0, and PC_s=00.
- INT_Vector holds its last value outside VECT.
- Reset (any time, including mid-sequence): state IDLE. Pending flags, nest, src, edge history, INTA_*, Write_*, Set_*, Restore_CPSR and busy = 0. PC_s=00, INT_Vector=0. A level held high across reset release is not a request until it falls and rises again.

## Timing
- Edge at cycle n (EX sampled at rising edge n) -> pend set at edge n.
- ACK at n+1, SAVE at n+2, VECT at n+3, SERVICE from n+4.
- Entry latency: 3 cycles from pend set to Write_PC.
- ret sampled in SERVICE at edge m -> RET during cycle m+1 -> SERVICE or IDLE at m+2.
- ret outside SERVICE is ignored.
- Mask bits are sampled only at arbitration. A mask change after the ACK decision does not abort the sequence.
- Each control pulse is exactly one cycle. No two of ACK, SAVE, VECT or RET overlap.

## Test plan
- Single IRQ: CPSR_7=0, EX_irq 0->1 -> INTA_irq, then Write_LR/Write_SPSR, then Write_PC with PC_s=11, INT_Vector=0x18, Set_I=1 in consecutive cycles. ret -> Write_PC with PC_s=10, Restore_CPSR=1, then IDLE, busy=0.
- Simultaneous EX_irq/EX_fiq edges, both unmasked -> FIQ entry (0x1C, Set_F=1). After FIQ ret, IRQ entry with 0x18.
- Nesting: IRQ in SERVICE, CPSR_6=0, FIQ edge -> nest=1, FIQ entry. First ret -> SERVICE with IRQ active, nest=0. Second ret -> IDLE.
- Masking: CPSR_7=1, IRQ edge -> no INTA, pend held. CPSR_7 -> 0 -> entry begins on the next cycle.
- Merge and set-wins: three IRQ edges before ACK -> one entry. An edge on the ACK cycle -> pend stays 1 and a second entry follows ret.
- Reset in VECT -> all outputs 0 / PC_s=00 immediately. EX_irq held high across release -> no entry until a new edge.
